// File: rtl/dmem_arb_pkg.sv
// Shared types and constants for the data-memory arbiter.
package dmem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } dmem_arb_state_t;

  localparam int DMEM_ARB_NREQ       = 2;
  localparam int DMEM_ARB_ALIGN_BITS = 3;

endpackage

// File: rtl/rr_arb2.sv
// Combinational 2-way grant select.
// DMEM_ARB_RR_EN defined: round-robin on ties; undefined: port 0 fixed priority.
module rr_arb2 (
  input  logic [1:0] req,
`ifdef DMEM_ARB_RR_EN
  input  logic       last,
`endif
  output logic [1:0] gnt
);

  always_comb begin
    gnt = 2'b00;
`ifdef DMEM_ARB_RR_EN
    // On a tie the port that did not win last time goes next.
    if (req == 2'b11) gnt = last ? 2'b01 : 2'b10;
    else              gnt = req;
`else
    if (req[0])      gnt = 2'b01;
    else if (req[1]) gnt = 2'b10;
`endif
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-requester arbiter/sequencer for the 64-bit data memory (IDLE -> ACCESS -> RESP).
// Build option: DMEM_ARB_RR_EN selects round-robin ties, otherwise port 0 has priority.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int ADDR_W    = 64,
  parameter int DATA_W    = 64,
  parameter int MEM_BYTES = 1024
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [DMEM_ARB_NREQ-1:0]          req,
  input  logic [DMEM_ARB_NREQ-1:0]          req_we,
  input  logic [DMEM_ARB_NREQ*ADDR_W-1:0]   req_addr,
  input  logic [DMEM_ARB_NREQ*DATA_W-1:0]   req_wdata,
  output logic [DMEM_ARB_NREQ-1:0]          gnt,
  output logic [DMEM_ARB_NREQ-1:0]          rsp_valid,
  output logic [DATA_W-1:0]                 rsp_rdata,
  output logic                              rsp_err,
  output logic                              MemRead,
  output logic                              MemWrite,
  output logic [ADDR_W-1:0]                 mem_addr,
  output logic [DATA_W-1:0]                 mem_wdata,
  input  logic [DATA_W-1:0]                 mem_rdata,
  output dmem_arb_state_t                   dbg_state
);

  // Handshake: requester i holds req[i] and its req_* fields until it sees the
  // one-cycle gnt[i] (only ever in IDLE); the answer is a one-cycle rsp_valid[i].
  dmem_arb_state_t          state_q, state_d;
  logic [1:0]               arb_gnt;
  logic                     win_sel, win_q, we_q, err_q;
  logic                     sel_we, sel_illegal, grant_fire;
  logic [ADDR_W-1:0]        sel_addr, mem_addr_q;
  logic [DATA_W-1:0]        sel_wdata, mem_wdata_q, rsp_rdata_q;
`ifdef DMEM_ARB_RR_EN
  logic                     last_q;
`endif

  rr_arb2 u_arb (
    .req  (req),
`ifdef DMEM_ARB_RR_EN
    .last (last_q),
`endif
    .gnt  (arb_gnt)
  );

  assign grant_fire = (state_q == IDLE) && (arb_gnt != 2'b00);
  assign win_sel    = arb_gnt[1];
  assign sel_we     = win_sel ? req_we[1] : req_we[0];
  assign sel_addr   = win_sel ? req_addr[ADDR_W +: ADDR_W] : req_addr[0 +: ADDR_W];
  assign sel_wdata  = win_sel ? req_wdata[DATA_W +: DATA_W] : req_wdata[0 +: DATA_W];
  assign sel_illegal = (sel_addr[DMEM_ARB_ALIGN_BITS-1:0] != '0) ||
                       (sel_addr >= ADDR_W'(MEM_BYTES));

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (grant_fire) state_d = sel_illegal ? RESP : ACCESS;
      ACCESS:  state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Memory address/data registers only load on legal grants, so they hold
  // their last driven values across errors and idle cycles.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      win_q       <= 1'b0;
      we_q        <= 1'b0;
      err_q       <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      rsp_rdata_q <= '0;
`ifdef DMEM_ARB_RR_EN
      last_q      <= 1'b1;
`endif
    end else begin
      state_q <= state_d;
      if (grant_fire) begin
        win_q       <= win_sel;
        we_q        <= sel_we;
        err_q       <= sel_illegal;
        rsp_rdata_q <= '0;
`ifdef DMEM_ARB_RR_EN
        last_q      <= win_sel;
`endif
        if (!sel_illegal) begin
          mem_addr_q  <= sel_addr;
          mem_wdata_q <= sel_wdata;
        end
      end
      if (state_q == ACCESS && !we_q) rsp_rdata_q <= mem_rdata;
    end
  end

  assign gnt       = (state_q == IDLE) ? arb_gnt : 2'b00;
  assign MemWrite  = (state_q == ACCESS) &&  we_q;
  assign MemRead   = (state_q == ACCESS) && !we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign rsp_valid = (state_q == RESP) ? (win_q ? 2'b10 : 2'b01) : 2'b00;
  assign rsp_err   = (state_q == RESP) && err_q;
  assign rsp_rdata = rsp_rdata_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a response scoreboard and a behavioural memory.
module tb_dmem_arbiter;
  import dmem_arb_pkg::*;

  localparam int W = 67;  // {rsp_valid[1:0], rsp_err, rsp_rdata[63:0]}

  logic              clk, rst, mem_clr;
  logic [1:0]        req, req_we, gnt, rsp_valid;
  logic [127:0]      req_addr, req_wdata;
  logic [63:0]       rsp_rdata, mem_addr, mem_wdata, mem_rdata;
  logic              rsp_err, MemRead, MemWrite;
  dmem_arb_state_t   dbg_state;

  logic [63:0]       mem [0:127];
  logic [63:0]       ref_mem [0:127];
  logic [W-1:0]      exp_q[$];
  int                n_cmp = 0;
  int                n_fail = 0;
  int                n_rsp = 0;
  int                n_mem_en = 0;

  dmem_arbiter #(.ADDR_W(64), .DATA_W(64), .MEM_BYTES(1024)) dut (
    .clk(clk), .rst(rst), .req(req), .req_we(req_we), .req_addr(req_addr),
    .req_wdata(req_wdata), .gnt(gnt), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err), .MemRead(MemRead), .MemWrite(MemWrite), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .dbg_state(dbg_state)
  );

  // clock / memory model
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  assign mem_rdata = mem[mem_addr[9:3]];
  always @(posedge clk) begin
    if (mem_clr) for (int i = 0; i < 128; i++) mem[i] <= 64'd0;
    else if (MemWrite) mem[mem_addr[9:3]] <= mem_wdata;
  end

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [W-1:0] mk_exp(input int p, input logic err, input logic [63:0] rd);
    return {(p == 1) ? 2'b10 : 2'b01, err, rd};
  endfunction

  // scoreboard: every response strobe must match the oldest expectation
  always @(negedge clk) begin
    if (MemRead || MemWrite) n_mem_en++;
    if (rsp_valid !== 2'b00) begin
      n_rsp++;
      if (exp_q.size() == 0) check("unexpected_rsp", rsp_valid, 2'b00);
      else check("rsp", {rsp_valid, rsp_err, rsp_rdata}, exp_q.pop_front());
    end
  end

  // driver tasks
  task automatic drive(input int p, input logic we, input logic [63:0] addr,
                       input logic [63:0] wdata);
    req_we[p]            = we;
    req_addr[p*64 +: 64] = addr;
    req_wdata[p*64 +: 64] = wdata;
    req[p]               = 1'b1;
  endtask

  function automatic logic [W-1:0] model(input int p, input logic we, input logic [63:0] addr,
                                         input logic [63:0] wdata);
    logic        err;
    logic [63:0] rd;
    err = (addr[2:0] != 3'd0) || (addr >= 64'd1024);
    rd  = (!we && !err) ? ref_mem[addr[9:3]] : 64'd0;
    if (we && !err) ref_mem[addr[9:3]] = wdata;
    return mk_exp(p, err, rd);
  endfunction

  task automatic wait_drain(input string tag);
    for (int i = 0; i < 10 && exp_q.size() != 0; i++) begin
      @(negedge clk); #1;
    end
    check(tag, exp_q.size(), 0);
  endtask

  task automatic do_txn(input int p, input logic we, input logic [63:0] addr,
                        input logic [63:0] wdata);
    bit seen;
    @(posedge clk); #1;
    drive(p, we, addr, wdata);
    seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      @(negedge clk);
      if (gnt[p]) seen = 1'b1;
      else begin @(posedge clk); #1; end
    end
    check("gnt_seen", seen, 1);
    if (seen) exp_q.push_back(model(p, we, addr, wdata));
    @(posedge clk); #1;
    req[p] = 1'b0;
    wait_drain("rsp_seen");
  endtask

  initial begin
    int base, n_g;
    logic [1:0] exp_g;
    rst = 1'b1; mem_clr = 1'b1;
    req = '0; req_we = '0; req_addr = '0; req_wdata = '0;
    for (int i = 0; i < 128; i++) ref_mem[i] = 64'd0;

    // reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_gnt", gnt, 2'b00);
    check("rst_rsp_valid", rsp_valid, 2'b00);
    check("rst_rsp_err", rsp_err, 0);
    check("rst_rsp_rdata", rsp_rdata, 0);
    check("rst_memrw", {MemRead, MemWrite}, 2'b00);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_mem_wdata", mem_wdata, 0);
    check("rst_state", dbg_state, IDLE);
    rst = 1'b0; mem_clr = 1'b0;

    // port 0 store, cycle-exact timing
    @(posedge clk); #1;
    drive(0, 1'b1, 64'h8, 64'hDEADBEEF_00000001);
    @(negedge clk);
    check("t1_gnt", gnt, 2'b01);
    exp_q.push_back(model(0, 1'b1, 64'h8, 64'hDEADBEEF_00000001));
    @(posedge clk); #1;
    req = 2'b00;
    @(negedge clk);
    check("t1_memwrite", {MemRead, MemWrite}, 2'b01);
    check("t1_mem_addr", mem_addr, 64'h8);
    check("t1_mem_wdata", mem_wdata, 64'hDEADBEEF_00000001);
    check("t1_no_gnt", gnt, 2'b00);
    @(posedge clk); #1;
    @(negedge clk);
    check("t1_rsp_valid", rsp_valid, 2'b01);
    check("t1_rsp_err", rsp_err, 0);
    check("t1_idle_en", {MemRead, MemWrite}, 2'b00);

    do_txn(1, 1'b0, 64'h8, 64'd0);
    do_txn(0, 1'b1, 64'h10, 64'h1111_2222_3333_4444);
    do_txn(1, 1'b1, 64'h18, 64'h5555_6666_7777_8888);

    // both ports request for 12 cycles
    base = n_rsp;
    n_g  = 0;
    @(posedge clk); #1;
    drive(0, 1'b0, 64'h10, 64'd0);
    drive(1, 1'b0, 64'h18, 64'd0);
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (gnt != 2'b00) begin
`ifdef DMEM_ARB_RR_EN
        exp_g = (n_g % 2 == 0) ? 2'b01 : 2'b10;
`else
        exp_g = 2'b01;
`endif
        check("tie_gnt", gnt, exp_g);
        exp_q.push_back(model(gnt[1] ? 1 : 0, 1'b0, gnt[1] ? 64'h18 : 64'h10, 64'd0));
        n_g++;
      end
    end
    @(posedge clk); #1;
    req = 2'b00;
    @(negedge clk); #1;
    check("tie_gnt_count", n_g, 4);
    check("tie_rsp_count", n_rsp - base, 4);
    check("tie_drained", exp_q.size(), 0);

    // misaligned load on port 1
    base = n_mem_en;
    @(posedge clk); #1;
    drive(1, 1'b0, 64'hC, 64'd0);
    @(negedge clk);
    check("mis_gnt", gnt, 2'b10);
    exp_q.push_back(model(1, 1'b0, 64'hC, 64'd0));
    @(posedge clk); #1;
    req = 2'b00;
    @(negedge clk);
    check("mis_rsp_valid", rsp_valid, 2'b10);
    check("mis_rsp_err", rsp_err, 1);
    check("mis_rsp_rdata", rsp_rdata, 0);
    @(posedge clk); #1;
    @(negedge clk);
    check("mis_no_mem_en", n_mem_en - base, 0);

    // out-of-range store must not alias onto word 0
    do_txn(0, 1'b1, 64'h0, 64'hCAFE_F00D_0000_0000);
    base = n_mem_en;
    do_txn(0, 1'b1, 64'h400, 64'hBAD0_BAD0_BAD0_BAD0);
    check("oor_no_mem_en", n_mem_en - base, 0);
    do_txn(0, 1'b0, 64'h0, 64'd0);

    // address changed after grant: latched copy is used
    @(posedge clk); #1;
    drive(0, 1'b1, 64'h20, 64'hABCD_0000_1234_5678);
    @(negedge clk);
    check("lat_gnt", gnt, 2'b01);
    exp_q.push_back(model(0, 1'b1, 64'h20, 64'hABCD_0000_1234_5678));
    @(posedge clk); #1;
    req = 2'b00;
    req_addr[63:0]  = 64'h28;
    req_wdata[63:0] = 64'h0;
    @(negedge clk);
    check("lat_mem_addr", mem_addr, 64'h20);
    check("lat_mem_wdata", mem_wdata, 64'hABCD_0000_1234_5678);
    wait_drain("lat_rsp");
    do_txn(1, 1'b0, 64'h20, 64'd0);
    do_txn(1, 1'b0, 64'h28, 64'd0);

    // reset during ACCESS of a port 1 load
    @(posedge clk); #1;
    drive(1, 1'b0, 64'h8, 64'd0);
    @(negedge clk);
    check("rst_acc_gnt", gnt, 2'b10);
    @(posedge clk); #1;
    req = 2'b00;
    @(negedge clk);
    check("rst_acc_memread", MemRead, 1);
    #1 rst = 1'b1;
    #1;
    check("rst_acc_memrw", {MemRead, MemWrite}, 2'b00);
    check("rst_acc_mem_addr", mem_addr, 0);
    check("rst_acc_mem_wdata", mem_wdata, 0);
    check("rst_acc_rsp", {rsp_valid, rsp_err}, 3'b000);
    check("rst_acc_rdata", rsp_rdata, 0);
    check("rst_acc_state", dbg_state, IDLE);
    @(posedge clk); #1;
    rst = 1'b0;
    base = n_rsp;
    repeat (3) @(negedge clk);
    check("rst_acc_no_rsp", n_rsp - base, 0);
    @(posedge clk); #1;
    drive(0, 1'b0, 64'h10, 64'd0);
    drive(1, 1'b0, 64'h18, 64'd0);
    @(negedge clk);
    check("post_rst_tie", gnt, 2'b01);
    exp_q.push_back(model(0, 1'b0, 64'h10, 64'd0));
    @(posedge clk); #1;
    req = 2'b00;
    wait_drain("post_rst_rsp");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
